display_page_sched: RTL



---
 rtl/display_page_sched_pkg.sv | 35 +++
 rtl/display_page_sched_snapshot_hold.sv | 64 ++++++
 rtl/display_page_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/display_page_sched_pkg.sv
// Shared types for the display page scheduler:
// page indices, FSM states and the page-to-driver mode map.
package display_page_sched_pkg;

  localparam logic [2:0] PG_BANNER = 3'd0;
  localparam logic [2:0] PG_HIRES  = 3'd1;
  localparam logic [2:0] PG_FREQ   = 3'd2;
  localparam logic [2:0] PG_DUTY   = 3'd3;
  localparam logic [2:0] PG_WAVE   = 3'd4;
  localparam logic [2:0] PG_LAST   = 3'd4;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] dip;
    logic       msel;
  } page_cfg_t;

  function automatic page_cfg_t page_map(input logic [2:0] p);
    page_cfg_t c;
    c = '{dip: 2'b00, msel: 1'b0};
    unique case (1'b1)
      (p == PG_HIRES): c.dip = 2'b01;
      (p == PG_FREQ):  c.dip = 2'b10;
      (p == PG_DUTY):  c.dip = 2'b11;
      (p == PG_WAVE):  c = '{dip: 2'b11, msel: 1'b1};
      default:         c = '{dip: 2'b00, msel: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/display_page_sched_snapshot_hold.sv
// Refresh-paced snapshot of frequency and duty data so the
// displayed digits only change at refresh boundaries.
module display_page_sched_snapshot_hold
  import display_page_sched_pkg::*;
#(
  parameter int REFRESH_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] freq_data,
  input  logic        freq_valid,
  input  logic [15:0] duty_data,
  input  logic        duty_valid,
  output logic [31:0] freq_hold,
  output logic [15:0] duty_hold,
  output logic        hold_upd
);

  localparam int RW = $clog2(REFRESH_TICKS);

  logic [RW-1:0] rcnt;
  logic [31:0]   freq_pend;
  logic [15:0]   duty_pend;
  logic          pend_f;
  logic          pend_d;
  logic          wrap;
  logic          commit;

  assign wrap   = (rcnt == RW'(REFRESH_TICKS - 1));
  assign commit = wrap && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt      <= '0;
      freq_pend <= '0;
      duty_pend <= '0;
      pend_f    <= 1'b0;
      pend_d    <= 1'b0;
      freq_hold <= '0;
      duty_hold <= '0;
      hold_upd  <= 1'b0;
    end else begin
      rcnt     <= wrap ? '0 : rcnt + 1'b1;
      hold_upd <= commit && (pend_f || pend_d);
      // a strobe on the wrap cycle re-arms the flag for the next wrap
      if (freq_valid) begin
        freq_pend <= freq_data;
        pend_f    <= 1'b1;
      end else if (commit) begin
        pend_f    <= 1'b0;
      end
      if (duty_valid) begin
        duty_pend <= duty_data;
        pend_d    <= 1'b1;
      end else if (commit) begin
        pend_d    <= 1'b0;
      end
      if (commit && pend_f) freq_hold <= freq_pend;
      if (commit && pend_d) duty_hold <= duty_pend;
    end
  end

endmodule

// File: rtl/display_page_sched.sv
// Page sequencer for the seven-segment display: auto/manual
// page selection with a blanking gap, plus held measurement data.
module display_page_sched
  import display_page_sched_pkg::*;
#(
  parameter int DWELL_TICKS   = 2000,
  parameter int REFRESH_TICKS = 500,
  parameter int BLANK_TICKS   = 4
) (
  input  logic        freq_source,
  input  logic        rst,
  input  logic        auto_en,
  input  logic [2:0]  man_page,
  input  logic        freeze,
  input  logic [31:0] freq_data,
  input  logic        freq_valid,
  input  logic [15:0] duty_data,
  input  logic        duty_valid,
  output logic [2:0]  page_idx,
  output logic [1:0]  page_dip,
  output logic        page_mode_sel,
  output logic        blank,
  output logic [31:0] freq_hold,
  output logic [15:0] duty_hold,
  output logic        hold_upd
);

  localparam int DW = $clog2(DWELL_TICKS);
  localparam int BW = $clog2(BLANK_TICKS + 1);

  state_t        state, state_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0]    next_page, next_n;
  logic [2:0]    page_n;
  logic          blank_n;
  page_cfg_t     cfg_n;

  assign cfg_n = page_map(page_n);

  always_ff @(posedge freq_source) begin
    if (rst) begin
      state         <= ST_SHOW;
      dwell         <= '0;
      bcnt          <= '0;
      next_page     <= PG_BANNER;
      page_idx      <= PG_BANNER;
      page_dip      <= 2'b00;
      page_mode_sel <= 1'b0;
      blank         <= 1'b0;
    end else begin
      state         <= state_n;
      dwell         <= dwell_n;
      bcnt          <= bcnt_n;
      next_page     <= next_n;
      page_idx      <= page_n;
      page_dip      <= cfg_n.dip;
      page_mode_sel <= cfg_n.msel;
      blank         <= blank_n;
    end
  end

  always_comb begin
    state_n = state;
    dwell_n = dwell;
    bcnt_n  = bcnt;
    next_n  = next_page;
    page_n  = page_idx;
    blank_n = blank;
    unique case (state)
      ST_SHOW: begin
        bcnt_n = '0;
        if (auto_en) begin
          if (dwell == DW'(DWELL_TICKS - 1)) begin
            dwell_n = '0;
            next_n  = (page_idx == PG_LAST) ? PG_BANNER
                                            : page_idx + 3'd1;
            state_n = ST_BLANK;
            blank_n = 1'b1;
          end else begin
            dwell_n = dwell + 1'b1;
          end
        end else begin
          dwell_n = '0;
          if (man_page <= PG_LAST && man_page != page_idx) begin
            next_n  = man_page;
            state_n = ST_BLANK;
            blank_n = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        // new page lands on the same edge that blank drops
        if (bcnt == BW'(BLANK_TICKS - 1)) begin
          state_n = ST_SHOW;
          blank_n = 1'b0;
          page_n  = next_page;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: state_n = ST_SHOW;
    endcase
  end

  display_page_sched_snapshot_hold #(
    .REFRESH_TICKS(REFRESH_TICKS)
  ) u_snap (
    .clk       (freq_source),
    .rst       (rst),
    .freeze    (freeze),
    .freq_data (freq_data),
    .freq_valid(freq_valid),
    .duty_data (duty_data),
    .duty_valid(duty_valid),
    .freq_hold (freq_hold),
    .duty_hold (duty_hold),
    .hold_upd  (hold_upd)
  );

endmodule
